// File: rtl/cpu_ctrl_fsm.sv
// Moore sequencer for the cpu datapath; w=1 only in WAIT, optional retired-instruction counter under CPU_CTRL_PERF_EN.
// Latency (posedges, start edge inclusive): MOV imm 3, MOV reg/MVN/CMP 5, ADD/AND 6, illegal 2.
// No backpressure: s is sampled only in WAIT and ignored while an instruction is in flight.
module cpu_ctrl_fsm #(
  parameter int CNT_W          = 16,
  parameter bit ILLEGAL_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic [1:0] alu_op,
  output logic       illegal
`ifdef CPU_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_count
`endif
);

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_GET_A  = 3'd2;
  localparam logic [2:0] S_GET_B  = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_WR_REG = 3'd5;
  localparam logic [2:0] S_WR_IMM = 3'd6;

  localparam logic [4:0] I_MOV_IMM = 5'b110_10;
  localparam logic [4:0] I_MOV_REG = 5'b110_00;
  localparam logic [4:0] I_ADD     = 5'b101_00;
  localparam logic [4:0] I_CMP     = 5'b101_01;
  localparam logic [4:0] I_AND     = 5'b101_10;
  localparam logic [4:0] I_MVN     = 5'b101_11;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [4:0] instr;
  logic       is_cmp;
  logic       is_unary;
  logic       start;
  logic       dec_bad;

  assign is_cmp   = (instr == I_CMP);
  assign is_unary = (instr == I_MOV_REG) || (instr == I_MVN);
  assign start    = (state == S_WAIT) && s;
  assign dec_bad  = (state == S_DECODE) && (state_nxt == S_WAIT);

  always_comb begin
    state_nxt = S_WAIT;
    case (state)
      S_WAIT:   state_nxt = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        case (instr)
          I_MOV_IMM:                  state_nxt = S_WR_IMM;
          I_MOV_REG, I_MVN:           state_nxt = S_GET_B;
          I_ADD, I_CMP, I_AND:        state_nxt = S_GET_A;
          default:                    state_nxt = S_WAIT;
        endcase
      end
      S_GET_A:  state_nxt = S_GET_B;
      S_GET_B:  state_nxt = S_EXEC;
      S_EXEC:   state_nxt = is_cmp ? S_WAIT : S_WR_REG;
      S_WR_REG: state_nxt = S_WAIT;
      S_WR_IMM: state_nxt = S_WAIT;
      default:  state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_WAIT;
      instr   <= 5'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        instr   <= {opcode, op};
        illegal <= 1'b0;
      end else if (dec_bad) begin
        illegal <= 1'b1;
      end else if (!ILLEGAL_STICKY && state == S_WAIT) begin
        illegal <= 1'b0;
      end
    end
  end

  always_comb begin
    w     = (state == S_WAIT);
    nsel  = 3'b000;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    vsel  = 2'b00;
    write = 1'b0;
    case (state)
      S_GET_A: begin
        nsel  = 3'b100;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = 3'b001;
        loadb = 1'b1;
      end
      S_EXEC: begin
        asel  = is_unary;
        loads = is_cmp;
        loadc = !is_cmp;
      end
      S_WR_REG: begin
        nsel  = 3'b010;
        write = 1'b1;
      end
      S_WR_IMM: begin
        nsel  = 3'b100;
        vsel  = 2'b01;
        write = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU opcodes for the 101 group map straight from op; MOV variants use ADD.
  assign alu_op = (state != S_WAIT && instr[4:2] == 3'b101) ? instr[1:0] : 2'b00;

`ifdef CPU_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_count <= '0;
    end else if (state == S_WR_REG || state == S_WR_IMM || (state == S_EXEC && is_cmp)) begin
      instr_count <= instr_count + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed scoreboard bench for cpu_ctrl_fsm: per-cycle expected control vectors queued at start, compared each cycle.
module tb_cpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w, loada, loadb, loadc, loads, asel, bsel, write, illegal;
  logic [2:0] nsel;
  logic [1:0] vsel, alu_op;
`ifdef CPU_CTRL_PERF_EN
  logic [15:0] instr_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;
  logic exp_ill = 1'b0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  cpu_ctrl_fsm dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel), .write(write),
    .alu_op(alu_op), .illegal(illegal)
`ifdef CPU_CTRL_PERF_EN
    , .instr_count(instr_count)
`endif
  );

  // {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, alu_op, illegal}
  function automatic logic [15:0] mk(logic ww, logic [2:0] ns, logic la, logic lb, logic lc,
                                     logic ls, logic as, logic [1:0] vs, logic wr,
                                     logic [1:0] alu, logic ill);
    return {ww, ns, la, lb, lc, ls, as, 1'b0, vs, wr, alu, ill};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(string tag);
    logic [15:0] e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk(tag, {16'h0, w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, alu_op, illegal},
          {16'h0, e});
    end
  endtask

  task automatic idle(int n);
    s = 1'b0;
    for (int i = 0; i < n; i++) begin
      sb.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, exp_ill));
      step("idle");
    end
  endtask

  // Issue one instruction; the expected sequence comes from the ISA control table.
  task automatic run(string tag, logic [2:0] opc, logic [1:0] o, int lat, logic keep_s);
    logic [4:0] ins;
    logic [1:0] alu;
    logic       bad;
    int         cyc;
    int         lat_obs;
    ins = {opc, o};
    alu = (opc == 3'b101) ? o : 2'b00;
    bad = 1'b0;
    opcode = opc;
    op = o;
    s = 1'b1;
    sb.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, alu, 0));
    case (ins)
      5'b110_10: sb.push_back(mk(0, 3'b100, 0, 0, 0, 0, 0, 2'b01, 1, alu, 0));
      5'b110_00, 5'b101_11: begin
        sb.push_back(mk(0, 3'b001, 0, 1, 0, 0, 0, 2'b00, 0, alu, 0));
        sb.push_back(mk(0, 3'b000, 0, 0, 1, 0, 1, 2'b00, 0, alu, 0));
        sb.push_back(mk(0, 3'b010, 0, 0, 0, 0, 0, 2'b00, 1, alu, 0));
      end
      5'b101_00, 5'b101_10: begin
        sb.push_back(mk(0, 3'b100, 1, 0, 0, 0, 0, 2'b00, 0, alu, 0));
        sb.push_back(mk(0, 3'b001, 0, 1, 0, 0, 0, 2'b00, 0, alu, 0));
        sb.push_back(mk(0, 3'b000, 0, 0, 1, 0, 0, 2'b00, 0, alu, 0));
        sb.push_back(mk(0, 3'b010, 0, 0, 0, 0, 0, 2'b00, 1, alu, 0));
      end
      5'b101_01: begin
        sb.push_back(mk(0, 3'b100, 1, 0, 0, 0, 0, 2'b00, 0, alu, 0));
        sb.push_back(mk(0, 3'b001, 0, 1, 0, 0, 0, 2'b00, 0, alu, 0));
        sb.push_back(mk(0, 3'b000, 0, 0, 0, 1, 0, 2'b00, 0, alu, 0));
      end
      default: bad = 1'b1;
    endcase
    sb.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, bad));
    exp_ill = bad;
    if (!bad) exp_cnt++;
    cyc = 0;
    lat_obs = 0;
    while (sb.size() != 0) begin
      step(tag);
      cyc++;
      if (cyc == 1 && !keep_s) s = 1'b0;
      if (w === 1'b1 && lat_obs == 0) lat_obs = cyc;
    end
    chk({tag, "_latency"}, lat_obs, lat);
  endtask

  initial begin
    reset = 1'b0;
    s = 1'b0;
    opcode = 3'b000;
    op = 2'b00;
    // Reset held two edges.
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));
      step("reset");
    end
`ifdef CPU_CTRL_PERF_EN
    chk("count_reset", {16'h0, instr_count}, 32'd0);
`endif
    reset = 1'b1;
    opcode = 3'b111;
    op = 2'b11;
    idle(5);

    run("mov_imm", 3'b110, 2'b10, 3, 1'b0);
    run("add",     3'b101, 2'b00, 6, 1'b0);
    run("cmp",     3'b101, 2'b01, 5, 1'b0);
    run("mvn",     3'b101, 2'b11, 5, 1'b0);
    run("mov_reg", 3'b110, 2'b00, 5, 1'b0);
    run("and",     3'b101, 2'b10, 6, 1'b0);

    run("illegal_111", 3'b111, 2'b00, 2, 1'b0);
    idle(2);
    run("illegal_110_01", 3'b110, 2'b01, 2, 1'b0);
    idle(1);

    run("b2b_add", 3'b101, 2'b00, 6, 1'b1);
    run("b2b_mov", 3'b110, 2'b10, 3, 1'b1);
    run("b2b_cmp", 3'b101, 2'b01, 5, 1'b0);
    idle(2);
`ifdef CPU_CTRL_PERF_EN
    chk("count_retired", {16'h0, instr_count}, exp_cnt);
`endif

    // Abort an ADD in GET_B with reset; nothing may be written afterwards.
    opcode = 3'b101;
    op = 2'b00;
    s = 1'b1;
    sb.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));
    sb.push_back(mk(0, 3'b100, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));
    sb.push_back(mk(0, 3'b001, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0));
    step("abort_decode");
    s = 1'b0;
    step("abort_get_a");
    step("abort_get_b");
    reset = 1'b0;
    exp_ill = 1'b0;
    exp_cnt = 0;
    sb.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));
    step("abort_reset");
    reset = 1'b1;
    idle(3);
`ifdef CPU_CTRL_PERF_EN
    chk("count_after_reset", {16'h0, instr_count}, 32'd0);
`endif
    run("post_reset_mov", 3'b110, 2'b10, 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
